// File: rtl/lcd_ram_refresh.sv
// HD44780 8-bit init sequencer and 16-char line-1 refresher.
// Ports: clk, rst, start; ram_addr/ram_data RAM read port; lcd_rs/rw/e/db bus; busy, done status.
module lcd_ram_refresh #(
  parameter int unsigned INIT_WAIT = 750000,
  parameter int unsigned SETUP     = 2,
  parameter int unsigned E_PULSE   = 12,
  parameter int unsigned CMD_WAIT  = 2500,
  parameter int unsigned CLR_WAIT  = 100000,
  parameter int unsigned TW        = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [3:0] ram_addr,
  input  logic [7:0] ram_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_db,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_PWR_WAIT,
    S_CMD,
    S_FETCH,
    S_LATCH,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_IDLE
  } state_t;

  localparam logic [TW-1:0] INIT_LAST  = TW'(INIT_WAIT - 1);
  localparam logic [TW-1:0] SETUP_LAST = TW'(SETUP - 1);
  localparam logic [TW-1:0] PULSE_LAST = TW'(E_PULSE - 1);
  localparam logic [TW-1:0] CMD_LAST   = TW'(CMD_WAIT - 1);
  localparam logic [TW-1:0] CLR_LAST   = TW'(CLR_WAIT - 1);

  state_t        state;
  state_t        state_d;
  logic [TW-1:0] timer;
  logic [3:0]    idx;
  logic [1:0]    step;
  // init_mode: running power-up commands; data_mode: 0x80 sent, now data bytes
  logic          init_mode;
  logic          data_mode;

  logic [TW-1:0] hold_last;
  logic          init_last;
  logic          last_byte;
  logic          hold_end;
  logic [7:0]    cmd_byte;

  always_comb begin
    init_last = init_mode && (step == 2'd3);
    last_byte = !init_mode && data_mode && (idx == 4'hF);
    hold_last = init_last ? CLR_LAST : CMD_LAST;
    hold_end  = (state == S_HOLD) && (timer == hold_last);
  end

  always_comb begin
    cmd_byte = 8'h80;
    unique case (1'b1)
      !init_mode:                cmd_byte = 8'h80;
      init_mode && step == 2'd0: cmd_byte = 8'h38;
      init_mode && step == 2'd1: cmd_byte = 8'h0C;
      init_mode && step == 2'd2: cmd_byte = 8'h06;
      init_mode && step == 2'd3: cmd_byte = 8'h01;
      default:                   cmd_byte = 8'h80;
    endcase
  end

  always_comb begin
    state_d = state;
    unique case (state)
      S_PWR_WAIT: if (timer == INIT_LAST) state_d = S_CMD;
      S_CMD:      state_d = S_SETUP;
      S_FETCH:    state_d = S_LATCH;
      S_LATCH:    state_d = S_SETUP;
      S_SETUP:    if (timer == SETUP_LAST) state_d = S_PULSE;
      S_PULSE:    if (timer == PULSE_LAST) state_d = S_HOLD;
      S_HOLD: begin
        if (hold_end) begin
          if (init_last || last_byte) state_d = S_IDLE;
          else if (init_mode)         state_d = S_CMD;
          else                        state_d = S_FETCH;
        end
      end
      S_IDLE:     if (start) state_d = S_CMD;
      default:    state_d = S_PWR_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_PWR_WAIT;
      timer     <= '0;
      idx       <= '0;
      step      <= '0;
      init_mode <= 1'b1;
      data_mode <= 1'b0;
      lcd_db    <= '0;
      lcd_rs    <= 1'b0;
      lcd_e     <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_d;
      // timer restarts on every state change so each phase counts from 0
      if (state_d != state || state == S_IDLE) timer <= '0;
      else                                     timer <= timer + 1'b1;
      lcd_e <= (state_d == S_PULSE);
      done  <= hold_end && last_byte;
      if (state == S_CMD) begin
        lcd_db <= cmd_byte;
        lcd_rs <= 1'b0;
      end
      if (state == S_LATCH) begin
        lcd_db <= ram_data;
        lcd_rs <= 1'b1;
      end
      if (hold_end) begin
        if (init_mode) begin
          if (step == 2'd3) init_mode <= 1'b0;
          else              step      <= step + 2'd1;
        end else if (data_mode) begin
          // 4-bit wrap leaves idx at 0 after the 16th byte
          idx <= idx + 4'd1;
          if (idx == 4'hF) data_mode <= 1'b0;
        end else begin
          data_mode <= 1'b1;
        end
      end
    end
  end

  assign ram_addr = idx;
  assign lcd_rw   = 1'b0;
  assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_lcd_ram_refresh.sv
// Scoreboard bench for lcd_ram_refresh with a registered-address RAM model.
// Stimulus pushes expected LCD bytes / done cycles; a negedge monitor pops and compares.
module tb_lcd_ram_refresh;
  localparam int INIT_WAIT = 10;
  localparam int SETUP     = 2;
  localparam int E_PULSE   = 3;
  localparam int CMD_WAIT  = 4;
  localparam int CLR_WAIT  = 6;
  localparam int CMD_LEN   = 1 + SETUP + E_PULSE + CMD_WAIT;
  localparam int INIT_LEN  = INIT_WAIT + 3 * CMD_LEN + (1 + SETUP + E_PULSE + CLR_WAIT);
  localparam int REF_LEN   = CMD_LEN + 16 * (2 + SETUP + E_PULSE + CMD_WAIT);
  localparam int NEVER     = 32'h3fffffff;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] ram_addr;
  logic [7:0] ram_data;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_db;
  logic       busy;
  logic       done;

  lcd_ram_refresh #(
    .INIT_WAIT(INIT_WAIT), .SETUP(SETUP), .E_PULSE(E_PULSE),
    .CMD_WAIT(CMD_WAIT), .CLR_WAIT(CLR_WAIT), .TW(20)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .ram_addr(ram_addr), .ram_data(ram_data),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_db(lcd_db),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [16];
  logic [3:0] addr_q;
  always @(posedge clk) addr_q <= ram_addr;
  assign ram_data = mem[addr_q];

  typedef struct {
    bit         rs;
    bit         from_ram;
    int         idx;
    logic [7:0] val;
  } lcd_byte_t;

  lcd_byte_t exp_q[$];
  int        done_q[$];
  int        checks = 0;
  int        failures = 0;
  int        cyc = 0;
  int        busy_end = NEVER;
  bit        rst_prev = 1'b1;
  bit        e_prev = 1'b0;
  int        e_len = 0;
  int        last_fall = -1000;
  int        last_change = 0;
  logic [8:0] bus_prev = '0;
  logic [8:0] bus_at_rise = '0;
  int        data_pulses = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, req);
    end
  endtask

  function automatic void push_cmd(input logic [7:0] v);
    lcd_byte_t b;
    b.rs = 1'b0; b.from_ram = 1'b0; b.idx = 0; b.val = v;
    exp_q.push_back(b);
  endfunction

  function automatic void push_init();
    push_cmd(8'h38);
    push_cmd(8'h0C);
    push_cmd(8'h06);
    push_cmd(8'h01);
  endfunction

  function automatic void push_refresh();
    lcd_byte_t b;
    push_cmd(8'h80);
    for (int i = 0; i < 16; i++) begin
      b.rs = 1'b1; b.from_ram = 1'b1; b.idx = i; b.val = 8'h00;
      exp_q.push_back(b);
    end
  endfunction

  always @(negedge clk) begin
    bit         exp_busy;
    bit         exp_done;
    lcd_byte_t  b;
    logic [7:0] want;
    exp_busy = rst_prev || (cyc < busy_end);
    if (rst_prev) begin
      check("rst_e", lcd_e, 0);
      check("rst_db", lcd_db, 0);
      check("rst_rs", lcd_rs, 0);
      check("rst_addr", ram_addr, 0);
      check("rst_done", done, 0);
      exp_q.delete();
      done_q.delete();
      busy_end = NEVER;
      last_fall = -1000;
      if (!rst) begin
        busy_end = cyc + INIT_LEN;
        push_init();
      end
    end
    check("busy", busy, exp_busy);
    exp_done = (done_q.size() > 0) && (done_q[0] == cyc);
    if (done || exp_done) begin
      check("done", done, exp_done);
      if (exp_done) begin
        void'(done_q.pop_front());
        check("addr_idle", ram_addr, 0);
      end
    end
    if ({lcd_rs, lcd_db} !== bus_prev) last_change = cyc;
    if (lcd_e && !e_prev) begin
      e_len = 1;
      bus_at_rise = {lcd_rs, lcd_db};
      check("rw", lcd_rw, 0);
      check("setup", (cyc - last_change) >= SETUP, 1);
      check("e_gap", (cyc - last_fall) >= (1 + SETUP + CMD_WAIT), 1);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL extra_pulse cyc=%0d got=%0h want=none", cyc, {lcd_rs, lcd_db});
      end else begin
        b = exp_q.pop_front();
        want = b.from_ram ? mem[b.idx] : b.val;
        check("byte", {lcd_rs, lcd_db}, {b.rs, want});
        if (b.from_ram) data_pulses++;
      end
    end else if (lcd_e) begin
      e_len++;
      check("bus_hold", {lcd_rs, lcd_db}, bus_at_rise);
    end else if (e_prev) begin
      last_fall = cyc;
      if (!rst_prev) check("e_width", e_len, E_PULSE);
    end
    if (start && !rst && !exp_busy) begin
      busy_end = cyc + 1 + REF_LEN;
      done_q.push_back(cyc + 1 + REF_LEN);
      push_refresh();
      data_pulses = 0;
    end
    bus_prev = {lcd_rs, lcd_db};
    e_prev = lcd_e;
    rst_prev = rst;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while (cyc < busy_end && n < maxc) begin
      tick();
      n++;
    end
    if (n >= maxc) begin
      checks++;
      failures++;
      $display("FAIL wait_idle cyc=%0d got=busy want=idle", cyc);
    end
  endtask

  task automatic rand_mem();
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic refresh_once(input int hold);
    start = 1'b1;
    repeat (hold) tick();
    start = 1'b0;
    wait_idle(REF_LEN + 40);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout cyc=%0d got=running want=finished", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    // start held through most of init must be ignored
    start = 1'b1;
    repeat (40) tick();
    start = 1'b0;
    wait_idle(INIT_LEN + 20);
    repeat (5) tick();

    for (int i = 0; i < 16; i++) mem[i] = 8'(8'h41 + i);
    refresh_once(1);
    repeat (3) tick();

    // start held high during a refresh
    rand_mem();
    refresh_once(150);
    repeat (2) tick();

    // back-to-back: second start on the done cycle
    rand_mem();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (REF_LEN) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(REF_LEN + 40);
    repeat (2) tick();

    // RAM[15] rewritten mid-refresh
    rand_mem();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (60) tick();
    mem[15] = 8'h7A;
    wait_idle(REF_LEN + 40);

    for (int r = 0; r < 4; r++) begin
      rand_mem();
      repeat ($urandom_range(0, 5)) tick();
      refresh_once($urandom_range(1, 30));
    end

    // reset while E is high on data byte 7
    rand_mem();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(lcd_e && data_pulses == 7) && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) begin
      checks++;
      failures++;
      $display("FAIL find_byte7 cyc=%0d got=timeout want=pulse", cyc);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_idle(INIT_LEN + 20);
    repeat (3) tick();
    rand_mem();
    refresh_once(1);

    repeat (5) tick();
    check("exp_q_empty", exp_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
